// File: rtl/memory_types_pkg.sv
// Shared types for the cache-to-memory arbiter: RAM status codes, arbiter
// states, grant identities and the default word width.
package memory_types_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        DGRANT,
        IGRANT
    } arb_state_t;

    typedef enum logic {
        INSTR,
        DATA
    } grant_t;

endpackage

// File: rtl/memory_arbiter.sv
// Serialises icache fetches and dcache reads/writes onto one single-port RAM,
// alternating grants on contention and returning wait/load handshakes.
module memory_arbiter
    import memory_types_pkg::*;
#(
    parameter int WORD_W = memory_types_pkg::WORD_W
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    arb_state_t state_q, state_d;
    grant_t     last_grant_q, last_grant_d;

    logic       d_req;
    logic       i_req;
    logic       ram_access;

    assign d_req      = dREN | dWEN;
    assign i_req      = iREN;
    assign ram_access = (ramstate_t'(ramstate) == ACCESS);

    // Read data is passed straight through; it only means something in the
    // requester's completion cycle.
    assign iload = ramload;
    assign dload = ramload;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            last_grant_q <= INSTR;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        iwait        = 1'b1;
        dwait        = 1'b1;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;

        case (state_q)
            IDLE: begin
                // On a tie the side that was not served last goes next.
                if (d_req && i_req) begin
                    state_d = (last_grant_q == INSTR) ? DGRANT : IGRANT;
                end else if (d_req) begin
                    state_d = DGRANT;
                end else if (i_req) begin
                    state_d = IGRANT;
                end
            end

            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                // A dropped request aborts without completing or touching last_grant.
                if (!d_req) begin
                    state_d = IDLE;
                end else if (ram_access) begin
                    dwait        = 1'b0;
                    last_grant_d = DATA;
                    state_d      = IDLE;
                end
            end

            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (!i_req) begin
                    state_d = IDLE;
                end else if (ram_access) begin
                    iwait        = 1'b0;
                    last_grant_d = INSTR;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios followed by
// randomized traffic against a transaction-level memory/fairness model.
module tb_memory_arbiter;
    import memory_types_pkg::*;

    localparam int STALL_LIMIT = 60;
    localparam int RAND_CYCLES = 3000;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait;
    logic [31:0] iload, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    int vectors = 0;
    int misses  = 0;

    memory_arbiter #(.WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    // Initial memory image shared by the RAM model and the reference copy.
    function automatic logic [31:0] seed_word(input int idx);
        if (idx == 16) return 32'h8C010004;
        return (32'(idx) * 32'h9E3779B9) ^ 32'h13579BDF;
    endfunction

    // RAM model: answers ACCESS once an enable has been held ram_lat cycles.
    logic [31:0] ram_mem [256];
    bit          ram_written [256];
    logic [31:0] ref_mem [256];
    int          ram_lat   = 1;
    int          ram_cnt   = 0;
    bit          force_err = 1'b0;
    bit          err_now   = 1'b0;

    always_comb begin
        if (!(ramREN || ramWEN))      ramstate = FREE;
        else if (force_err || err_now) ramstate = ERROR;
        else if (ram_cnt >= ram_lat)   ramstate = ACCESS;
        else                           ramstate = BUSY;
    end

    assign ramload = ram_written[ramaddr[9:2]] ? ram_mem[ramaddr[9:2]]
                                               : seed_word(int'(ramaddr[9:2]));

    always @(posedge CLK) begin
        if (ramstate == ACCESS) begin
            ram_cnt <= 0;
            if (ramWEN) begin
                ram_mem[ramaddr[9:2]]     <= ramstore;
                ram_written[ramaddr[9:2]] <= 1'b1;
            end
        end else if (ramstate == BUSY) begin
            ram_cnt <= ram_cnt + 1;
        end else if (ramstate == FREE) begin
            ram_cnt <= 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            misses++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic i_en, input logic [31:0] i_a,
                                 input logic d_rd, input logic d_wr,
                                 input logic [31:0] d_a, input logic [31:0] d_s);
        iREN   = i_en;
        iaddr  = i_a;
        dREN   = d_rd;
        dWEN   = d_wr;
        daddr  = d_a;
        dstore = d_s;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        nRST = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // Returns the number of cycles sampled before completion, or -1 on timeout.
    task automatic waitDone(input bit is_data, output int cycles);
        cycles = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (is_data ? !dwait : !iwait) begin
                cycles = c;
                return;
            end
            step();
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          first_done, n_done, d_low, cyc, n;
        logic [3:0]  seq;
        bit          i_active, d_active, i_done, d_done, d_wr;
        logic [31:0] i_addr, d_addr, d_data;
        int          i_age, d_age, i_skips, d_skips, op;

        for (int k = 0; k < 256; k++) ref_mem[k] = seed_word(k);

        // Reset state with requests already asserted.
        nRST = 1'b0;
        applyStimulus(1, 32'h44, 1, 1, 32'h88, 32'h1234);
        #2;
        checkOutput("rst_iwait", iwait, 1);
        checkOutput("rst_dwait", dwait, 1);
        checkOutput("rst_ramren", ramREN, 0);
        checkOutput("rst_ramwen", ramWEN, 0);
        checkOutput("rst_ramaddr", ramaddr, 0);
        checkOutput("rst_ramstore", ramstore, 0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        checkOutput("rst_held_ramren", ramREN, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        nRST = 1'b1;

        // Instruction-only read, RAM latency 2.
        ram_lat = 2;
        step();
        applyStimulus(1, 32'h40, 0, 0, 0, 0);
        first_done = -1; n_done = 0; d_low = 0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                step();
                if (n_done > 0) applyStimulus(0, 0, 0, 0, 0, 0);
            end
            @(negedge CLK);
            if (c == 0) checkOutput("i_arb_cycle_ramren", ramREN, 0);
            if (c == 1) begin
                checkOutput("i_ramren", ramREN, 1);
                checkOutput("i_ramwen", ramWEN, 0);
                checkOutput("i_ramaddr", ramaddr, 32'h40);
            end
            if (!dwait) d_low++;
            if (!iwait) begin
                if (first_done < 0) first_done = c;
                n_done++;
                checkOutput("i_load", iload, 32'h8C010004);
            end
        end
        checkOutput("i_done_cycle", first_done, 3);
        checkOutput("i_done_count", n_done, 1);
        checkOutput("i_dwait_held", d_low, 0);

        // Data write, RAM latency 1, then read it back.
        ram_lat = 1;
        step();
        applyStimulus(0, 0, 0, 1, 32'h100, 32'hDEADBEEF);
        first_done = -1; n_done = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                step();
                if (n_done > 0) applyStimulus(0, 0, 0, 0, 0, 0);
            end
            @(negedge CLK);
            if (c == 1) begin
                checkOutput("w_ramwen", ramWEN, 1);
                checkOutput("w_ramren", ramREN, 0);
                checkOutput("w_ramaddr", ramaddr, 32'h100);
                checkOutput("w_ramstore", ramstore, 32'hDEADBEEF);
                checkOutput("w_dwait_busy", dwait, 1);
            end
            if (!dwait) begin
                if (first_done < 0) first_done = c;
                n_done++;
            end
        end
        ref_mem[64] = 32'hDEADBEEF;
        checkOutput("w_done_cycle", first_done, 2);
        checkOutput("w_done_count", n_done, 1);
        step();
        applyStimulus(0, 0, 1, 0, 32'h100, 0);
        waitDone(1, cyc);
        checkOutput("rb_latency", cyc, 2);
        checkOutput("rb_dload", dload, ref_mem[64]);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Contention straight after reset: data first, then strict alternation.
        doReset();
        ram_lat = 1;
        step();
        applyStimulus(1, 32'h8, 1, 0, 32'hC, 0);
        seq = '0; n = 0; cyc = -1;
        for (int c = 0; c < 30 && n < 4; c++) begin
            if (c > 0) step();
            @(negedge CLK);
            if (!dwait) begin
                seq = {seq[2:0], 1'b1};
                n++;
                cyc = c;
                checkOutput("ct_dload", dload, ref_mem[3]);
            end
            if (!iwait) begin
                seq = {seq[2:0], 1'b0};
                n++;
                cyc = c;
                checkOutput("ct_iload", iload, ref_mem[2]);
            end
        end
        checkOutput("ct_count", n, 4);
        checkOutput("ct_order_DIDI", {28'd0, seq}, 32'hA);
        checkOutput("ct_last_cycle", cyc, 11);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);

        // dREN and dWEN together: the write wins.
        step();
        applyStimulus(0, 0, 1, 1, 32'h8, 32'hCAFEF00D);
        @(negedge CLK);
        step();
        @(negedge CLK);
        checkOutput("rw_ramwen", ramWEN, 1);
        checkOutput("rw_ramren", ramREN, 0);
        checkOutput("rw_ramstore", ramstore, 32'hCAFEF00D);
        step();
        waitDone(1, cyc);
        checkOutput("rw_latency", cyc, 0);
        ref_mem[2] = 32'hCAFEF00D;
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Abort an instruction grant while the RAM is busy.
        ram_lat = 5;
        step();
        applyStimulus(1, 32'h20, 0, 0, 0, 0);
        @(negedge CLK);
        step();
        @(negedge CLK);
        checkOutput("ab_grant_ramren", ramREN, 1);
        checkOutput("ab_grant_addr", ramaddr, 32'h20);
        step();
        applyStimulus(0, 32'h20, 0, 0, 0, 0);
        @(negedge CLK);
        checkOutput("ab_drop_ramren", ramREN, 0);
        checkOutput("ab_drop_iwait", iwait, 1);
        step();
        applyStimulus(0, 0, 1, 0, 32'h10, 0);
        @(negedge CLK);
        checkOutput("ab_idle_ramren", ramREN, 0);
        step();
        @(negedge CLK);
        checkOutput("ab_d_ramren", ramREN, 1);
        checkOutput("ab_d_addr", ramaddr, 32'h10);
        step();
        waitDone(1, cyc);
        checkOutput("ab_d_latency", cyc, 4);
        checkOutput("ab_d_dload", dload, ref_mem[4]);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);

        // ERROR never completes; reset mid-grant drops everything at once.
        ram_lat = 1;
        force_err = 1'b1;
        step();
        applyStimulus(0, 0, 1, 0, 32'h14, 0);
        @(negedge CLK);
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge CLK);
            checkOutput("err_dwait", dwait, 1);
            checkOutput("err_ramren", ramREN, 1);
        end
        step();
        #2;
        nRST = 1'b0;
        #1;
        checkOutput("mid_rst_ramren", ramREN, 0);
        checkOutput("mid_rst_ramwen", ramWEN, 0);
        checkOutput("mid_rst_iwait", iwait, 1);
        checkOutput("mid_rst_dwait", dwait, 1);
        checkOutput("mid_rst_ramaddr", ramaddr, 0);
        force_err = 1'b0;
        applyStimulus(1, 32'h18, 1, 0, 32'h1C, 0);
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        step();
        @(negedge CLK);
        checkOutput("post_rst_tie_addr", ramaddr, 32'h1C);
        checkOutput("post_rst_tie_ramren", ramREN, 1);
        checkOutput("post_rst_iwait", iwait, 1);
        step();
        waitDone(1, cyc);
        checkOutput("post_rst_d_latency", cyc, 0);
        checkOutput("post_rst_dload", dload, ref_mem[7]);
        step();
        applyStimulus(1, 32'h18, 0, 0, 0, 0);
        waitDone(0, cyc);
        checkOutput("post_rst_i_latency", cyc, 2);
        checkOutput("post_rst_iload", iload, ref_mem[6]);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Randomized traffic with aborts and sporadic ERROR responses.
        i_active = 0; d_active = 0; i_done = 0; d_done = 0; d_wr = 0;
        i_addr = 0; d_addr = 0; d_data = 0;
        i_age = 0; d_age = 0; i_skips = 0; d_skips = 0;
        for (int cyc_n = 0; cyc_n < RAND_CYCLES; cyc_n++) begin
            step();
            if (cyc_n % 256 == 0) ram_lat = $urandom_range(0, 3);
            if (i_done) i_active = 0;
            if (d_done) d_active = 0;
            if (!i_active) begin
                if ($urandom_range(0, 1) == 1) begin
                    i_active = 1;
                    i_addr   = 32'($urandom_range(0, 15)) << 2;
                    i_age    = 0;
                    i_skips  = 0;
                end
            end else if ($urandom_range(0, 39) == 0) begin
                i_active = 0;
            end
            if (!d_active) begin
                if ($urandom_range(0, 1) == 1) begin
                    d_active = 1;
                    op       = $urandom_range(0, 3);
                    d_wr     = (op >= 2);
                    d_addr   = 32'($urandom_range(0, 15)) << 2;
                    d_data   = $urandom;
                    d_age    = 0;
                    d_skips  = 0;
                end
            end else if ($urandom_range(0, 39) == 0) begin
                d_active = 0;
            end
            err_now = ($urandom_range(0, 9) == 0);
            applyStimulus(i_active, i_addr, d_active && (op != 2), d_active && d_wr,
                          d_addr, d_data);

            @(negedge CLK);
            i_done = i_active && !iwait;
            d_done = d_active && !dwait;
            if (i_active) i_age++;
            if (d_active) d_age++;
            checkOutput("r_single_completion", 32'({iwait, dwait} == 2'b00), 0);
            if (ramWEN) checkOutput("r_wen_excl", ramREN, 0);
            if (!i_active) checkOutput("r_i_idle_wait", iwait, 1);
            if (!d_active) checkOutput("r_d_idle_wait", dwait, 1);
            if (!i_active && !d_active) checkOutput("r_ram_quiet", {ramREN, ramWEN}, 0);
            if (i_done) begin
                checkOutput("r_i_addr", ramaddr, i_addr);
                checkOutput("r_iload", iload, ref_mem[i_addr[9:2]]);
                checkOutput("r_i_age_ok", 32'(i_age <= STALL_LIMIT), 1);
                if (d_active) begin
                    d_skips++;
                    checkOutput("r_d_not_starved", 32'(d_skips <= 1), 1);
                end
            end
            if (d_done) begin
                checkOutput("r_d_addr", ramaddr, d_addr);
                checkOutput("r_d_age_ok", 32'(d_age <= STALL_LIMIT), 1);
                if (d_wr) begin
                    checkOutput("r_d_ramwen", ramWEN, 1);
                    checkOutput("r_d_ramstore", ramstore, d_data);
                    ref_mem[d_addr[9:2]] = d_data;
                end else begin
                    checkOutput("r_d_ramren", ramREN, 1);
                    checkOutput("r_dload", dload, ref_mem[d_addr[9:2]]);
                end
                if (i_active) begin
                    i_skips++;
                    checkOutput("r_i_not_starved", 32'(i_skips <= 1), 1);
                end
            end
            if (i_active && !i_done && i_age > STALL_LIMIT) begin
                checkOutput("r_i_stall", i_age, STALL_LIMIT);
                i_active = 0;
            end
            if (d_active && !d_done && d_age > STALL_LIMIT) begin
                checkOutput("r_d_stall", d_age, STALL_LIMIT);
                d_active = 0;
            end
        end

        step();
        err_now = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Responder end of the cache-to-memory request interface.
- Accepts instruction-fetch requests (icache side) and data read/write requests (dcache side), and serialises them onto one single-port RAM.
- Returns wait/load handshakes to each requester.
- Sits between the caches block and the RAM model or top-level memory.

Parameters:
WORD_W, 32, data and address width in bits.

Ports:
CLK  input  1  system clock, rising edge.
nRST  input  1  asynchronous, active-low reset.
iREN  input  1  instruction read request.
iaddr  input  WORD_W  instruction address.
iwait  output  1  1 = instruction request not complete this cycle.
iload  output  WORD_W  instruction read data.
dREN  input  1  data read request.
dWEN  input  1  data write request.
daddr  input  WORD_W  data address.
dstore  input  WORD_W  data write value.
dwait  output  1  1 = data request not complete this cycle.
dload  output  WORD_W  data read data.
ramREN  output  1  RAM read enable.
ramWEN  output  1  RAM write enable.
ramaddr  output  WORD_W  RAM address.
ramstore  output  WORD_W  RAM write data.
ramload  input  WORD_W  RAM read data.
ramstate  input  2  RAM status (ramstate_t).

Behaviour:
- Reset:
  - State IDLE; last_grant = INSTR, so data wins the first tie.
  - During reset: iwait = dwait = 1; ramREN = ramWEN = 0; ramaddr = ramstore = 0.
  - Reset is asynchronous on nRST low and aborts any in-flight grant; no completion is signalled.
- Load data: iload = dload = ramload at all times, combinationally. Data is valid only in the requester's completion cycle.
- FSM states: IDLE, DGRANT, IGRANT. The state register is clocked; all outputs are combinational from state and inputs.
- IDLE:
  - Drives no RAM enables; iwait = dwait = 1.
  - Next state:
    - Data pending (dREN|dWEN) and instr pending: grant the requester that is not last_grant.
    - Only data pending: DGRANT.
    - Only instr pending: IGRANT.
    - Neither: stay IDLE.
  - A grant costs one arbitration cycle; the RAM sees the request starting the cycle after it is raised.
- DGRANT:
  - ramaddr = daddr, ramstore = dstore.
  - If dWEN is high: ramWEN = 1, ramREN = 0. dWEN wins when dREN and dWEN are both high.
  - Otherwise: ramREN = dREN.
  - iwait = 1.
  - dwait = 0 exactly in a cycle where ramstate == ACCESS; else 1.
  - On ACCESS: set last_grant = DATA and go to IDLE.
- IGRANT:
  - ramaddr = iaddr, ramREN = 1, ramWEN = 0, ramstore = 0.
  - dwait = 1.
  - iwait = 0 exactly when ramstate == ACCESS.
  - On ACCESS: set last_grant = INSTR and go to IDLE.
- Abort: if the granted requester drops its enable(s) before ACCESS, the RAM enables deassert that same cycle. Go to IDLE with no completion; last_grant is unchanged.
- ramstate FREE, BUSY or ERROR in a grant state: hold the grant and keep wait = 1. ERROR is never treated as completion.
- Throughput: at most one completion per two cycles per requester. Back-to-back requests from both sides alternate, so neither side starves.
- Requesters must hold address, data and enable until their wait drops. The arbiter does not latch them.

Decomposition:
- Package memory_types_pkg:
  - ramstate_t enum: FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3.
  - arb_state_t: IDLE, DGRANT, IGRANT.
  - grant_t: INSTR, DATA.
  - WORD_W default constant.
- No sub-module; a single FSM module.

Test Plan:
- Instr-only read: iREN = 1, iaddr = 0x40; RAM gives ACCESS 2 cycles after ramREN -> ramREN rises 1 cycle after iREN. iwait = 0 for exactly one cycle, with iload = ramload = 0x8C010004. dwait stays 1 throughout.
- Data write: dWEN = 1, daddr = 0x100, dstore = 0xDEADBEEF -> ramWEN = 1, ramaddr = 0x100, ramstore = 0xDEADBEEF, ramREN = 0. dwait = 0 on the ACCESS cycle only.
- Contention after reset: iREN and dREN raised together and held, RAM latency 1 -> completion order is D, I, D, I. No second consecutive D while I is pending.
- dREN and dWEN both high -> only ramWEN asserted.
- Abort: iREN dropped in IGRANT while ramstate = BUSY -> ramREN = 0 that cycle, FSM returns to IDLE, iwait never 0. A subsequent dREN is granted next.
- ERROR then reset: ramstate held at ERROR in DGRANT for 5 cycles -> dwait stays 1. Assert nRST = 0 mid-grant -> ramREN/ramWEN drop immediately, iwait = dwait = 1. After release the FSM is IDLE and the first tie goes to data.
